game_score_ctrl: RTL and testbench

Synchronous controller that owns the score/lives state of a game and feeds the scoreboard digit generator. It collects scoring pulses from several requesters, arbitrates them into a single BCD score adder, and sequences the game through attract, play, dying and game-over states. It presents frame-stable score and lives digits that change only at vsync, so the scoreboard never tears mid-frame.

---
 rtl/game_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 64 ++++++
 rtl/game_score_ctrl.sv | 138 +++++++++++++
 tb/tb_game_score_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the game score controller.
//   state_e    - game state encoding (ATTRACT=0, PLAY=1, DYING=2, OVER=3)
//   DigitW     - width of one BCD digit
//   BlankDigit - digit code the scoreboard generator renders as blank
//   bcd_inc    - saturating two-digit BCD increment
package game_pkg;

  typedef enum logic [1:0] {
    StAttract = 2'd0,
    StPlay    = 2'd1,
    StDying   = 2'd2,
    StOver    = 2'd3
  } state_e;

  localparam int unsigned DigitW = 4;
  localparam logic [DigitW-1:0] BlankDigit = 4'd15;

  // {tens, units} + 1 in BCD; 99 sticks at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99) begin
      return v;
    end else if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter, at most one grant per cycle.
//   i_clk   - clock
//   i_rst_n - synchronous active-low reset (pointer back to 0)
//   i_en    - grants allowed this cycle
//   i_req   - N request bits
//   o_gnt   - one-hot grant (all zero when idle or disabled)
// The pointer holds the index where the next search starts; it moves to
// one past the granted source.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] r_ptr;
  logic [PtrW-1:0] w_ptr_d;
  logic [PtrW-1:0] w_idx;
  logic [PtrW-1:0] w_j;
  logic [PtrW:0]   w_sum;
  logic            w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    w_sum   = '0;
    w_j     = '0;
    for (int i = 0; i < int'(N); i++) begin
      // (ptr + i) mod N without a divider
      w_sum = {1'b0, r_ptr} + (PtrW + 1)'(i);
      if (w_sum >= (PtrW + 1)'(N)) begin
        w_sum = w_sum - (PtrW + 1)'(N);
      end
      w_j = w_sum[PtrW-1:0];
      if (i_en && !w_found && i_req[w_j]) begin
        w_found    = 1'b1;
        w_idx      = w_j;
        o_gnt[w_j] = 1'b1;
      end
    end
  end

  always_comb begin
    w_ptr_d = r_ptr;
    if (w_found) begin
      w_ptr_d = (w_idx == PtrW'(N - 1)) ? '0 : w_idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_d;
    end
  end

endmodule

// File: rtl/game_score_ctrl.sv
// game_score_ctrl: owns score/lives and the game state machine.
//   clk         - system clock
//   reset       - synchronous active-low reset
//   vsync       - frame sync; rising edge is the frame tick
//   start       - start button level
//   score_req   - one-cycle score pulses, one per requester
//   die         - one-cycle life-lost pulse
//   score0/1    - displayed score units/tens (BCD), updated on tick only
//   lives       - displayed lives (BCD), updated on tick only
//   state       - game state
//   play_en     - high in PLAY
//   lives_blank - flash control for the lives digit while dying
module game_score_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NSRC         = 4,
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned DEATH_FRAMES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              start,
  input  logic [NSRC-1:0]   score_req,
  input  logic              die,
  output logic [DigitW-1:0] score0,
  output logic [DigitW-1:0] score1,
  output logic [DigitW-1:0] lives,
  output logic [1:0]        state,
  output logic              play_en,
  output logic              lives_blank
);

  localparam logic [DigitW-1:0] StartLives = DigitW'(START_LIVES);
  localparam logic [7:0]        DeathCnt   = 8'(DEATH_FRAMES);

  state_e            r_state, w_state_d;
  logic              r_play_en;
  logic              r_vsync_q;
  logic [NSRC-1:0]   r_pend, w_pend_d;
  logic [7:0]        r_wscore, w_wscore_d;  // {tens, units}
  logic [DigitW-1:0] r_wlives, w_wlives_d;
  logic [7:0]        r_fcnt, w_fcnt_d;
  logic [DigitW-1:0] r_score0, r_score1, r_lives;
  logic [NSRC-1:0]   w_gnt;
  logic              w_tick;
  logic              w_play;

  assign w_tick = vsync & ~r_vsync_q;
  assign w_play = (r_state == StPlay);

  rr_arbiter #(
    .N(NSRC)
  ) u_arb (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_en   (w_play),
    .i_req  (r_pend),
    .o_gnt  (w_gnt)
  );

  always_comb begin
    w_state_d  = r_state;
    w_wscore_d = r_wscore;
    w_wlives_d = r_wlives;
    w_fcnt_d   = r_fcnt;
    w_pend_d   = '0;  // pending requests only survive in PLAY
    unique case (r_state)
      StAttract, StOver: begin
        if (start) begin
          w_wscore_d = '0;
          w_wlives_d = StartLives;
          w_state_d  = StPlay;
        end
      end
      StPlay: begin
        // a same-cycle request re-arms a bit that is being granted
        w_pend_d = (r_pend & ~w_gnt) | score_req;
        if (|w_gnt) begin
          w_wscore_d = bcd_inc(r_wscore);
        end
        if (die) begin
          w_wlives_d = r_wlives - 4'd1;
          if (r_wlives == 4'd1) begin
            w_state_d = StOver;
          end else begin
            w_state_d = StDying;
            w_fcnt_d  = DeathCnt;
          end
        end
      end
      StDying: begin
        if (r_fcnt == '0) begin
          w_state_d = StPlay;
        end else if (w_tick) begin
          w_fcnt_d = r_fcnt - 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= StAttract;
      r_play_en <= 1'b0;
      r_vsync_q <= 1'b0;
      r_pend    <= '0;
      r_wscore  <= '0;
      r_wlives  <= StartLives;
      r_fcnt    <= '0;
      r_score0  <= '0;
      r_score1  <= '0;
      r_lives   <= StartLives;
    end else begin
      r_state   <= w_state_d;
      r_play_en <= (w_state_d == StPlay);
      r_vsync_q <= vsync;
      r_pend    <= w_pend_d;
      r_wscore  <= w_wscore_d;
      r_wlives  <= w_wlives_d;
      r_fcnt    <= w_fcnt_d;
      // display samples the work registers as they were before this edge
      if (w_tick) begin
        r_score0 <= r_wscore[3:0];
        r_score1 <= r_wscore[7:4];
        r_lives  <= r_wlives;
      end
    end
  end

  assign score0      = r_score0;
  assign score1      = r_score1;
  assign lives       = r_lives;
  assign state       = r_state;
  assign play_en     = r_play_en;
  assign lives_blank = (r_state == StDying) & r_fcnt[3];

endmodule

// File: tb/tb_game_score_ctrl.sv
// Scoreboard bench for game_score_ctrl: the stimulus process queues the
// hand-computed expected outputs, the monitor pops and compares them.
module tb_game_score_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic       start;
  logic [3:0] score_req;
  logic       die;
  logic [3:0] score0, score1, lives;
  logic [1:0] state;
  logic       play_en, lives_blank;

  game_score_ctrl #(
    .NSRC        (4),
    .START_LIVES (3),
    .DEATH_FRAMES(64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .start      (start),
    .score_req  (score_req),
    .die        (die),
    .score0     (score0),
    .score1     (score1),
    .lives      (lives),
    .state      (state),
    .play_en    (play_en),
    .lives_blank(lives_blank)
  );

  always #5 clk = ~clk;

  // {state, score1, score0, lives, play_en, lives_blank}
  typedef struct {
    string       name;
    logic [15:0] v;
  } exp_t;

  exp_t sb_q[$];
  logic chk_req = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  always @(negedge clk) begin
    if (chk_req) begin
      exp_t        e;
      logic [15:0] act;
      act = {state, score1, score0, lives, play_en, lives_blank};
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL monitor: output presented with empty scoreboard");
      end else begin
        e = sb_q.pop_front();
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s: got st=%0d sc=%h%h lv=%h pe=%b bl=%b, want st=%0d sc=%h%h lv=%h pe=%b bl=%b",
                   e.name, act[15:14], act[13:10], act[9:6], act[5:2], act[1], act[0],
                   e.v[15:14], e.v[13:10], e.v[9:6], e.v[5:2], e.v[1], e.v[0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Guarantees a low vsync sample first so the rising edge is a real tick.
  task automatic tick();
    vsync = 1'b0;
    cyc();
    vsync = 1'b1;
    cyc();
    vsync = 1'b0;
  endtask

  task automatic chk(input string name, input logic [1:0] st, input logic [3:0] s1,
                     input logic [3:0] s0, input logic [3:0] lv, input logic pe,
                     input logic bl);
    exp_t e;
    e.name = name;
    e.v    = {st, s1, s0, lv, pe, bl};
    sb_q.push_back(e);
    chk_req = 1'b1;
    @(negedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; vsync = 1'b0; start = 1'b0; score_req = '0; die = 1'b0;
    repeat (3) cyc();
    reset = 1'b1;
    chk("reset", 2'd0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0);

    start = 1'b1; cyc(); start = 1'b0;
    chk("start_play", 2'd1, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0);
    tick();
    chk("first_tick", 2'd1, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0);

    // burst of four: grants land on the four edges after pend is set
    score_req = 4'b1111; cyc(); score_req = '0;
    tick();  // tick edge sees one grant already applied
    chk("burst_tick1", 2'd1, 4'd0, 4'd1, 4'd3, 1'b1, 1'b0);
    repeat (3) cyc();
    chk("burst_hold", 2'd1, 4'd0, 4'd1, 4'd3, 1'b1, 1'b0);
    tick();
    chk("burst_done", 2'd1, 4'd0, 4'd4, 4'd3, 1'b1, 1'b0);

    // first death, with a second die during DYING that must be ignored
    die = 1'b1; cyc(); die = 1'b0;
    chk("die_dying", 2'd2, 4'd0, 4'd4, 4'd3, 1'b0, 1'b0);
    die = 1'b1; cyc(); die = 1'b0;
    tick();  // fcnt 64 -> 63, bit3 set
    chk("dying_tick1", 2'd2, 4'd0, 4'd4, 4'd2, 1'b0, 1'b1);
    for (int n = 2; n <= 64; n++) begin
      tick();
      if (n == 8)  chk("blank_n8",  2'd2, 4'd0, 4'd4, 4'd2, 1'b0, 1'b1);  // fcnt 56
      if (n == 9)  chk("blank_n9",  2'd2, 4'd0, 4'd4, 4'd2, 1'b0, 1'b0);  // fcnt 55
      if (n == 17) chk("blank_n17", 2'd2, 4'd0, 4'd4, 4'd2, 1'b0, 1'b1);  // fcnt 47
    end
    chk("fcnt_zero", 2'd2, 4'd0, 4'd4, 4'd2, 1'b0, 1'b0);
    cyc();
    chk("back_play", 2'd1, 4'd0, 4'd4, 4'd2, 1'b1, 1'b0);

    // second death leaves one life
    die = 1'b1; cyc(); die = 1'b0;
    for (int n = 1; n <= 64; n++) tick();
    cyc();
    chk("second_die_play", 2'd1, 4'd0, 4'd4, 4'd1, 1'b1, 1'b0);

    // last life lost in the same cycle a grant is applied: both take effect
    score_req = 4'b0100; cyc(); score_req = '0;
    die = 1'b1; cyc(); die = 1'b0;
    chk("over_state", 2'd3, 4'd0, 4'd4, 4'd1, 1'b0, 1'b0);
    tick();
    chk("over_tick", 2'd3, 4'd0, 4'd5, 4'd0, 1'b0, 1'b0);
    score_req = 4'b1111; cyc(); score_req = '0; cyc();
    tick();
    chk("over_ignore", 2'd3, 4'd0, 4'd5, 4'd0, 1'b0, 1'b0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("restart", 2'd1, 4'd0, 4'd5, 4'd0, 1'b1, 1'b0);
    tick();
    chk("restart_tick", 2'd1, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0);

    // climb to 98, then saturate
    for (int k = 0; k < 98; k++) begin
      score_req = 4'b0001; cyc(); score_req = '0; cyc();
    end
    tick();
    chk("at_98", 2'd1, 4'd9, 4'd8, 4'd3, 1'b1, 1'b0);
    score_req = 4'b0010; cyc(); score_req = '0; cyc(); tick();
    chk("sat_1", 2'd1, 4'd9, 4'd9, 4'd3, 1'b1, 1'b0);
    score_req = 4'b0100; cyc(); score_req = '0; cyc(); tick();
    chk("sat_2", 2'd1, 4'd9, 4'd9, 4'd3, 1'b1, 1'b0);
    score_req = 4'b1000; cyc(); score_req = '0; cyc(); tick();
    chk("sat_3", 2'd1, 4'd9, 4'd9, 4'd3, 1'b1, 1'b0);

    start = 1'b1; repeat (4) cyc(); start = 1'b0;
    tick();
    chk("start_in_play", 2'd1, 4'd9, 4'd9, 4'd3, 1'b1, 1'b0);

    // reset while DYING with a request just latched
    score_req = 4'b1000; die = 1'b1; cyc(); score_req = '0; die = 1'b0;
    reset = 1'b0; cyc(); reset = 1'b1;
    chk("mid_reset", 2'd0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0);
    start = 1'b1; cyc(); start = 1'b0;
    repeat (4) cyc();
    tick();
    chk("post_reset", 2'd1, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0);

    for (int w = 0; w < 10 && sb_q.size() != 0; w++) cyc();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never compared, want 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
